des_round_sequencer: RTL and testbench
======================================

# des_round_sequencer

Controller that sequences the 64-bit DES state register through the external round function for a fixed number of rounds. It uses a 2:1 64-bit select to choose between loading fresh input data and feeding back the round-function output. It also generates the subkey index and handles the start/busy/done handshake. It sits between the block-level top and the combinational round datapath (expansion, S-boxes, permutation), which it drives through `Round_state` and `Key_idx`.

## Interface
- `DATA_W`, 64: state/data width; must be even.
- `ROUNDS`, 16: number of rounds per block; 2..16.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `Start`  in  1  request to process `Data_in`; sampled only in IDLE.
- `Mode`  in  1  0 = encrypt (key order ascending), 1 = decrypt (descending); sampled with `Start`.
- `Data_in`  in  `DATA_W`  input block, already initial-permuted by the top.
- `Round_in`  in  `DATA_W`  output of the external round function for the current `Round_state`/`Key_idx`.
- `Round_state`  out  `DATA_W`  registered state presented to the round function.
- `Key_idx`  out  4  subkey index for the current round.
- `Busy`  out  1  high while rounds are in progress.
- `Done`  out  1  one-cycle pulse; `Data_out` valid from this cycle.
- `Data_out`  out  `DATA_W`  registered result, half-swapped; held until the next `Done`.

## Operation
- FSM states: IDLE, RUN.
- IDLE + `Start`=1:
  - Mux selects `Data_in`; `Round_state` <= `Data_in`.
  - Round counter `cnt` <= 0; `mode_q` <= `Mode`.
  - Next state RUN.
- IDLE + `Start`=0: hold all registers.
- RUN, every cycle:
  - Mux selects `Round_in`; `Round_state` <= `Round_in`; `cnt` <= `cnt`+1.
- RUN with `cnt` == `ROUNDS`-1:
  - `Data_out` <= {`Round_in`[DATA_W/2-1:0], `Round_in`[DATA_W-1:DATA_W/2]}.
  - `Done` <= 1; next state IDLE.
- `Key_idx` is combinational from registered state: `mode_q` ? `ROUNDS`-1-`cnt` : `cnt` in RUN, 0 in IDLE.
- `Busy` = (state == RUN).
- `Done` is registered, so it rises in the first IDLE cycle after RUN.
  - A `Start` sampled in that same cycle is accepted, giving back-to-back blocks with no bubble.
- `Start` while `Busy`: ignored, not queued.
- `Mode` changes during RUN: no effect (`mode_q` used).
- `rst_n` low at any time, including mid-RUN: immediate return to IDLE.
  - Partial results are discarded; no `Done`.
- Reset values:
  - state = IDLE, `cnt` = 0.
  - `Round_state` = 0, `Data_out` = 0.
  - `Done` = 0, `Busy` = 0, `Key_idx` = 0.

## Timing
- Edge E0 samples `Start`. From E0 onward, `Busy`=1 and `Round_state`=`Data_in`.
- Edges E1..E`ROUNDS` apply rounds 1..`ROUNDS`.
- Edge E`ROUNDS` registers `Data_out` and `Done`.
- Latency `Start`-sample to `Done`: `ROUNDS` cycles (16 by default). Throughput: one block per `ROUNDS`+1 cycles when `Start` is held high.
- The round function is purely combinational within one cycle; the controller adds no internal pipeline.

## Structure
- Shared package `des_ctrl_pkg`:
  - state enum (IDLE, RUN).
  - `DES_ROUNDS` = 16.
  - `DES_BLOCK_W` = 64.
  - `KEY_IDX_W` = 4.
- Sub-module `state_sel_mux`: parameterised `DATA_W` 2:1 select (load vs feedback). Instantiated once; its select is driven by the FSM (1 in IDLE, 0 in RUN).
- Everything else (FSM, counter, output registers) is inline in `des_round_sequencer`.

## Test plan
- Reset: assert `rst_n`=0 with random inputs -> all outputs 0; `Busy`=0; no `Done`.
- Encrypt, bench round model `Round_in` = `Round_state`+1, `Data_in`=0x0000000000000000, `Mode`=0:
  - `Key_idx` sequence 0,1,..,15.
  - `Done` exactly 16 cycles after `Start` sampled.
  - `Data_out` = 0x0000001000000000.
- Decrypt, same model, `Data_in`=0x0123456789ABCDEF, `Mode`=1:
  - `Key_idx` sequence 15..0.
  - `Data_out` = 0x89ABCDFF01234567.
- `Start` pulsed at cycles 3 and 9 of RUN, and `Mode` toggled mid-RUN -> result and key order identical to the undisturbed run; only one `Done`.
- `rst_n` asserted at round 7 -> `Busy` falls immediately, no `Done`, `Data_out` = 0. A fresh `Start` after release completes normally.
- `Start` held high for 3 blocks -> `Done` pulses 17 cycles apart; each `Data_out` matches its own input.

Source files
------------

// File: rtl/des_ctrl_pkg.sv
// Shared types and constants for the DES round sequencer.
package des_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    localparam int DES_ROUNDS  = 16;
    localparam int DES_BLOCK_W = 64;
    localparam int KEY_IDX_W   = 4;

endpackage

// File: rtl/des_round_sequencer_state_sel_mux.sv
// 2:1 state select: fresh load data when sel=1, round feedback when sel=0.
module state_sel_mux #(
    parameter int DATA_W = 64
) (
    input  logic              sel,
    input  logic [DATA_W-1:0] load_data,
    input  logic [DATA_W-1:0] feedback_data,
    output logic [DATA_W-1:0] out_data
);

    assign out_data = sel ? load_data : feedback_data;

endmodule

// File: rtl/des_round_sequencer.sv
// Sequences the DES state register through the external round function,
// generating the subkey index and the start/busy/done handshake.
import des_ctrl_pkg::*;

module des_round_sequencer #(
    parameter int DATA_W = DES_BLOCK_W,
    parameter int ROUNDS = DES_ROUNDS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Start,
    input  logic                 Mode,
    input  logic [DATA_W-1:0]    Data_in,
    input  logic [DATA_W-1:0]    Round_in,
    output logic [DATA_W-1:0]    Round_state,
    output logic [KEY_IDX_W-1:0] Key_idx,
    output logic                 Busy,
    output logic                 Done,
    output logic [DATA_W-1:0]    Data_out
);

    localparam int                   HALF_W   = DATA_W / 2;
    localparam logic [KEY_IDX_W-1:0] LAST_CNT = KEY_IDX_W'(ROUNDS - 1);

    seq_state_t           state;
    seq_state_t           next_state;
    logic [KEY_IDX_W-1:0] cnt;
    logic                 mode_q;
    logic                 mux_sel;
    logic                 last_round;
    logic [DATA_W-1:0]    next_data;

    state_sel_mux #(
        .DATA_W (DATA_W)
    ) u_state_sel_mux (
        .sel           (mux_sel),
        .load_data     (Data_in),
        .feedback_data (Round_in),
        .out_data      (next_data)
    );

    assign last_round = (state == RUN) && (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mux_sel    = 1'b0;
        case (state)
            IDLE: begin
                mux_sel = 1'b1;
                if (Start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last_round) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Done is registered here, so it lands in the first IDLE cycle where a
    // new Start can already be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Round_state <= '0;
            Data_out    <= '0;
            cnt         <= '0;
            mode_q      <= 1'b0;
            Done        <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        Round_state <= next_data;
                        cnt         <= '0;
                        mode_q      <= Mode;
                    end
                end
                RUN: begin
                    Round_state <= next_data;
                    cnt         <= cnt + 1'b1;
                    if (last_round) begin
                        Data_out <= {Round_in[HALF_W-1:0], Round_in[DATA_W-1:HALF_W]};
                        Done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        Key_idx = '0;
        if (state == RUN) begin
            Key_idx = mode_q ? (LAST_CNT - cnt) : cnt;
        end
    end

    assign Busy = (state == RUN);

endmodule

// File: tb/tb_des_round_sequencer.sv
// Randomized self-checking bench for des_round_sequencer against a
// block-level reference model of the round sequencing.
module tb_des_round_sequencer;

    localparam int ROUNDS = 16;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic        Mode;
    logic [63:0] Data_in;
    logic [63:0] Round_in;
    logic [63:0] Round_state;
    logic [3:0]  Key_idx;
    logic        Busy;
    logic        Done;
    logic [63:0] Data_out;

    int          total;
    int          bad;
    int          cyc;
    bit          fn_sel;

    des_round_sequencer #(
        .DATA_W (64),
        .ROUNDS (ROUNDS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Start       (Start),
        .Mode        (Mode),
        .Data_in     (Data_in),
        .Round_in    (Round_in),
        .Round_state (Round_state),
        .Key_idx     (Key_idx),
        .Busy        (Busy),
        .Done        (Done),
        .Data_out    (Data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in round function: simple increment or a key-dependent mix.
    function automatic logic [63:0] round_fn(input logic [63:0] s, input logic [3:0] k, input bit sel);
        if (!sel) return s + 64'd1;
        return {s[62:0], s[63]} ^ ({60'd0, k} * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0F0F_0000_F0F0_5A5A;
    endfunction

    assign Round_in = round_fn(Round_state, Key_idx, fn_sel);

    function automatic logic [3:0] ref_key(input bit mode, input int r);
        return mode ? 4'(ROUNDS - 1 - r) : 4'(r);
    endfunction

    function automatic logic [63:0] ref_result(input logic [63:0] data, input bit mode, input bit sel);
        logic [63:0] s = data;
        for (int r = 0; r < ROUNDS; r++) s = round_fn(s, ref_key(mode, r), sel);
        return {s[31:0], s[63:32]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One block from an IDLE negedge; optional Start/Mode/Data_in noise mid-run.
    task automatic run_block(input logic [63:0] data, input bit mode, input bit disturb);
        logic [63:0] exp = ref_result(data, mode, fn_sel);
        Start   = 1'b1;
        Mode    = mode;
        Data_in = data;
        @(negedge clk);
        Start = 1'b0;
        check("load_state", Round_state, data);
        for (int r = 0; r < ROUNDS; r++) begin
            check("key_idx", {60'd0, Key_idx}, {60'd0, ref_key(mode, r)});
            check("busy_run", {63'd0, Busy}, 64'd1);
            check("done_low", {63'd0, Done}, 64'd0);
            if (disturb) begin
                if (r == 3 || r == 9) begin
                    Start   = 1'b1;
                    Data_in = {$urandom, $urandom};
                end else begin
                    Start = 1'b0;
                end
                if (r == 5) Mode = ~Mode;
            end
            @(negedge clk);
        end
        Start = 1'b0;
        check("done_pulse", {63'd0, Done}, 64'd1);
        check("busy_idle", {63'd0, Busy}, 64'd0);
        check("data_out", Data_out, exp);
        @(negedge clk);
        check("done_single", {63'd0, Done}, 64'd0);
        check("data_out_hold", Data_out, exp);
    endtask

    initial begin
        logic [63:0] blk_data [4];
        bit          blk_mode [4];
        int          last_done;

        total   = 0;
        bad     = 0;
        cyc     = 0;
        fn_sel  = 1'b0;
        rst_n   = 1'b1;
        Start   = 1'b0;
        Mode    = 1'b0;
        Data_in = '0;
        #1 rst_n = 1'b0;

        // Reset with random inputs toggling.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            Start   = 1'($urandom);
            Mode    = 1'($urandom);
            Data_in = {$urandom, $urandom};
            check("rst_state", Round_state, 64'd0);
            check("rst_out", Data_out, 64'd0);
            check("rst_flags", {59'd0, Key_idx, Busy, Done}, 64'd0);
        end
        @(negedge clk);
        Start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", {63'd0, Busy}, 64'd0);

        // Directed encrypt and decrypt with the increment round model.
        run_block(64'h0000_0000_0000_0000, 1'b0, 1'b0);
        check("enc_const", Data_out, 64'h0000_0010_0000_0000);
        run_block(64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
        check("dec_const", Data_out, 64'h89AB_CDFF_0123_4567);

        // Start pulses and Mode toggle mid-run must not disturb the block.
        fn_sel = 1'b1;
        run_block(64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
        run_block(64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b1);

        // Reset asserted at round 7.
        Start   = 1'b1;
        Mode    = 1'b0;
        Data_in = {$urandom, $urandom};
        @(negedge clk);
        Start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {63'd0, Busy}, 64'd0);
        check("midrst_state", Round_state, 64'd0);
        check("midrst_key", {60'd0, Key_idx}, 64'd0);
        @(negedge clk);
        check("midrst_done", {63'd0, Done}, 64'd0);
        check("midrst_out", Data_out, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_done2", {63'd0, Done}, 64'd0);
        run_block({$urandom, $urandom}, 1'b1, 1'b0);

        // Start held high for three back-to-back blocks.
        for (int b = 0; b < 4; b++) begin
            blk_data[b] = {$urandom, $urandom};
            blk_mode[b] = 1'($urandom);
        end
        last_done = 0;
        Start   = 1'b1;
        Data_in = blk_data[0];
        Mode    = blk_mode[0];
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            check("b2b_load", Round_state, blk_data[b]);
            Data_in = blk_data[b + 1];
            Mode    = blk_mode[b + 1];
            repeat (ROUNDS) @(negedge clk);
            check("b2b_done", {63'd0, Done}, 64'd1);
            check("b2b_out", Data_out, ref_result(blk_data[b], blk_mode[b], fn_sel));
            if (b > 0) check("b2b_gap", 64'(cyc - last_done), 64'(ROUNDS + 1));
            last_done = cyc;
        end
        Start = 1'b0;
        @(negedge clk);
        repeat (ROUNDS) @(negedge clk);

        // Randomized blocks with random idle gaps.
        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_block({$urandom, $urandom}, 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
